f_fetch_stage: RTL and testbench

//   F-stage of the 5-stage MIPS pipeline: owns the PC register, drives the instruction-memory address
//   and the F/D pipeline register feeding the D stage. Loads npc from the D-stage next-PC unit each

---
 rtl/f_fetch_stage_if.sv | 27 ++
 rtl/f_fetch_stage.sv | 90 +++++++++
 tb/tb_f_fetch_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/f_fetch_stage_if.sv
// Instruction-memory port and F/D pipeline-register outputs of the fetch stage.
interface f_fetch_stage_if;
   logic [11:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] D_pc;
   logic [31:0] D_instr;
   logic        D_valid;
   logic [4:0]  D_exccode;

   modport master (
      output im_addr,
      input  im_rdata,
      output D_pc,
      output D_instr,
      output D_valid,
      output D_exccode
   );

   modport slave (
      input  im_addr,
      output im_rdata,
      input  D_pc,
      input  D_instr,
      input  D_valid,
      input  D_exccode
   );
endinterface

// File: rtl/f_fetch_stage.sv
// MIPS F stage: PC register, IM addressing with AdEL detection, F/D register with
// stall/bubble control, and a counter of valid fetches.
module f_fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        D_flush,
   input  logic [31:0] npc,
   output logic [31:0] F_pc,
   output logic [31:0] fetch_cnt,
   f_fetch_stage_if.master bus
);

   localparam logic [32:0] IM_SPAN  = 33'(IM_WORDS) << 2;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] d_pc_q, d_pc_d;
   logic [31:0] d_instr_q, d_instr_d;
   logic        d_valid_q, d_valid_d;
   logic [4:0]  d_exccode_q, d_exccode_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic [32:0] pc_off_c;
   logic        f_exc_c;
   logic [31:0] f_instr_c;

   // Offset from IM base; the borrow bit flags a PC below the base.
   always_comb begin
      pc_off_c  = {1'b0, f_pc_q} - {1'b0, IM_BASE};
      f_exc_c   = (f_pc_q[1:0] != 2'b00) || pc_off_c[32] ||
                  ({1'b0, pc_off_c[31:0]} >= IM_SPAN);
      f_instr_c = f_exc_c ? 32'h0 : bus.im_rdata;
   end

   // Priority: stall > D_flush > normal fetch (reset handled in the register).
   always_comb begin
      f_pc_d      = f_pc_q;
      d_pc_d      = d_pc_q;
      d_instr_d   = d_instr_q;
      d_valid_d   = d_valid_q;
      d_exccode_d = d_exccode_q;
      fetch_cnt_d = fetch_cnt_q;
      if (!stall) begin
         f_pc_d = npc;
         d_pc_d = f_pc_q;
         if (D_flush) begin
            d_instr_d   = 32'h0;
            d_valid_d   = 1'b0;
            d_exccode_d = 5'd0;
         end else begin
            d_instr_d   = f_instr_c;
            d_valid_d   = 1'b1;
            d_exccode_d = f_exc_c ? EXC_ADEL : 5'd0;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         f_pc_q      <= PC_RESET;
         d_pc_q      <= 32'h0;
         d_instr_q   <= 32'h0;
         d_valid_q   <= 1'b0;
         d_exccode_q <= 5'd0;
         fetch_cnt_q <= 32'h0;
      end else begin
         f_pc_q      <= f_pc_d;
         d_pc_q      <= d_pc_d;
         d_instr_q   <= d_instr_d;
         d_valid_q   <= d_valid_d;
         d_exccode_q <= d_exccode_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign F_pc          = f_pc_q;
   assign fetch_cnt     = fetch_cnt_q;
   assign bus.im_addr   = pc_off_c[13:2];
   assign bus.D_pc      = d_pc_q;
   assign bus.D_instr   = d_instr_q;
   assign bus.D_valid   = d_valid_q;
   assign bus.D_exccode = d_exccode_q;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed bench for f_fetch_stage: a PC-level model checked every cycle plus literal pins.
module tb_f_fetch_stage;
   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int unsigned WORDS = 4096;
   localparam logic [31:0] LAST  = BASE + 32'(WORDS * 4) - 32'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        D_flush;
   logic [31:0] npc;
   logic [31:0] F_pc;
   logic [31:0] fetch_cnt;

   f_fetch_stage_if bus ();

   f_fetch_stage dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .D_flush   (D_flush),
      .npc       (npc),
      .F_pc      (F_pc),
      .fetch_cnt (fetch_cnt),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // IM contents: word k holds 32'hAB00_0000 + k.
   assign bus.im_rdata = 32'hAB00_0000 | 32'(bus.im_addr);

   int nerr = 0;
   int nchk = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_fpc, m_dpc, m_dinstr, m_cnt;
   logic        m_dvalid;
   logic [4:0]  m_dexc;

   function automatic bit illegal(input logic [31:0] pc);
      longint unsigned p;
      p = longint'(pc);
      return (pc % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * longint'(WORDS));
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'hAB00_0000 + (pc - BASE) / 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the F stage must hold after each edge.
   always @(posedge clk) begin
      if (!reset) begin
         m_fpc = BASE; m_dpc = 0; m_dinstr = 0; m_dvalid = 0; m_dexc = 0; m_cnt = 0;
      end else if (!stall) begin
         m_dpc = m_fpc;
         if (D_flush) begin
            m_dinstr = 0; m_dvalid = 0; m_dexc = 0;
         end else begin
            m_dinstr = illegal(m_fpc) ? 32'h0 : mem_word(m_fpc);
            m_dexc   = illegal(m_fpc) ? 5'd4 : 5'd0;
            m_dvalid = 1'b1;
            m_cnt    = m_cnt + 1;
         end
         m_fpc = npc;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("F_pc", F_pc, m_fpc);
         chk("im_addr", 32'(bus.im_addr), 32'(12'((m_fpc - BASE) >> 2)));
         chk("D_pc", bus.D_pc, m_dpc);
         chk("D_instr", bus.D_instr, m_dinstr);
         chk("D_valid", 32'(bus.D_valid), 32'(m_dvalid));
         chk("D_exccode", 32'(bus.D_exccode), 32'(m_dexc));
         chk("fetch_cnt", fetch_cnt, m_cnt);
      end
   end

   // Apply inputs, let one edge consume them, return 2 time units after it.
   task automatic drive(input logic r, input logic st, input logic fl,
                        input bit use_nv, input logic [31:0] nv);
      reset   = r;
      stall   = st;
      D_flush = fl;
      npc     = use_nv ? nv : m_fpc + 32'd4;
      @(posedge clk);
      #2;
   endtask

   initial begin
      m_fpc = BASE;
      drive(0, 0, 0, 1, 32'h0);
      drive(0, 0, 0, 1, 32'h0);
      chk("rst_F_pc", F_pc, 32'h3000);
      chk("rst_D_pc", bus.D_pc, 32'h0);
      chk("rst_D_valid", 32'(bus.D_valid), 32'h0);
      chk("rst_cnt", fetch_cnt, 32'h0);
      chk_en = 1'b1;

      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      chk("seq_F_pc", F_pc, 32'h3008);
      chk("seq_D_pc", bus.D_pc, 32'h3004);
      chk("seq_D_instr", bus.D_instr, 32'hAB00_0001);
      drive(1, 0, 0, 0, 0);
      chk("seq_cnt", fetch_cnt, 32'd3);

      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
      chk("stall_F_pc", F_pc, 32'h300C);
      chk("stall_D_pc", bus.D_pc, 32'h3008);
      chk("stall_cnt", fetch_cnt, 32'd3);
      drive(1, 0, 0, 0, 0);
      chk("resume_F_pc", F_pc, 32'h3010);

      drive(1, 1, 1, 0, 0);
      chk("stflush_valid", 32'(bus.D_valid), 32'h1);
      chk("stflush_D_pc", bus.D_pc, 32'h300C);
      drive(1, 0, 1, 0, 0);
      chk("flush_instr", bus.D_instr, 32'h0);
      chk("flush_valid", 32'(bus.D_valid), 32'h0);
      chk("flush_cnt", fetch_cnt, 32'd4);

      drive(1, 0, 0, 1, 32'h0000_3002);
      drive(1, 0, 0, 0, 0);
      chk("misal_D_pc", bus.D_pc, 32'h3002);
      chk("misal_instr", bus.D_instr, 32'h0);
      chk("misal_exc", 32'(bus.D_exccode), 32'd4);
      chk("misal_valid", 32'(bus.D_valid), 32'h1);
      chk("misal_cnt", fetch_cnt, 32'd6);

      drive(1, 0, 0, 1, LAST);
      drive(1, 0, 0, 0, 0);
      chk("last_exc", 32'(bus.D_exccode), 32'd0);
      chk("last_instr", bus.D_instr, 32'hAB00_0FFF);
      drive(1, 0, 0, 0, 0);
      chk("beyond_D_pc", bus.D_pc, 32'h7000);
      chk("beyond_exc", 32'(bus.D_exccode), 32'd4);

      drive(1, 0, 0, 1, 32'hFFFF_FFFC);
      drive(1, 0, 0, 0, 0);
      chk("wrap_F_pc", F_pc, 32'h0);
      drive(1, 0, 0, 0, 0);
      chk("wrap_exc", 32'(bus.D_exccode), 32'd4);

      drive(1, 0, 0, 1, 32'h0000_3040);
      drive(0, 1, 0, 0, 0);
      chk("rststall_F_pc", F_pc, 32'h3000);
      chk("rststall_D_valid", 32'(bus.D_valid), 32'h0);
      chk("rststall_cnt", fetch_cnt, 32'h0);
      drive(1, 1, 0, 0, 0);
      chk("poststall_F_pc", F_pc, 32'h3000);
      drive(1, 0, 0, 0, 0);
      chk("post_D_pc", bus.D_pc, 32'h3000);
      chk("post_instr", bus.D_instr, 32'hAB00_0000);
      chk("post_cnt", fetch_cnt, 32'd1);
      drive(1, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
